// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter unit: PCSrc selects, FSM states
// and the default exception vector.
package pc_unit_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect-target calculator: picks the branch, jump or
// jump-register target and flags a misaligned jump-register target.
module pc_target_calc
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       pc_src_i,
  input  logic [WIDTH-1:0] pc_plus4_i,
  input  logic [WIDTH-1:0] branch_off_i,
  input  logic [25:0]      jump_target_i,
  input  logic [WIDTH-1:0] reg_target_i,
  output logic [WIDTH-1:0] target_o,
  output logic             misaligned_o
);

  // Target select; only jump-register can produce a misaligned address.
  always_comb begin
    target_o     = pc_plus4_i;
    misaligned_o = 1'b0;
    case (pc_src_i)
      PC_BR: target_o = pc_plus4_i + (branch_off_i << 2);
      PC_J:  target_o = {pc_plus4_i[WIDTH-1:28], jump_target_i, 2'b00};
      PC_JR: begin
        target_o     = reg_target_i;
        misaligned_o = |reg_target_i[1:0];
      end
      default: target_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: owns the fetch address, applies redirects, buffers
// redirects seen while stalled, and handles reset-hold, halt and exceptions.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEFAULT),
  parameter int              RESET_HOLD = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] BranchOff,
  input  logic [25:0]      JumpTarget,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Excp,
  input  logic             Halt,
  output logic [WIDTH-1:0] CurrentAdd,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             Valid,
  output logic             AddrErr,
  output logic             Pending,
  output logic [1:0]       DbgState
);

  // Handshake: PCWre is an enable from the pipeline (1 = PC may advance on
  // this edge, 0 = stall); Valid qualifies CurrentAdd as a real fetch
  // address for the whole cycle and is low in HOLD and HALTED.

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;

  pc_state_e        state_q, state_d;
  logic [HW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_q, pend_d;
  logic             aerr_q, aerr_d;
  logic [WIDTH-1:0] tgt;
  logic             tgt_mis;

  assign PCPlus4 = pc_q + WIDTH'(4);

  pc_target_calc #(.WIDTH(WIDTH)) u_calc (
    .pc_src_i      (PCSrc),
    .pc_plus4_i    (PCPlus4),
    .branch_off_i  (BranchOff),
    .jump_target_i (JumpTarget),
    .reg_target_i  (RegTarget),
    .target_o      (tgt),
    .misaligned_o  (tgt_mis)
  );

  // Next-state logic: reset-hold countdown, then the RUN priority chain.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    aerr_d     = 1'b0;
    case (state_q)
      HOLD: begin
        // Count of 1 (or 0) means this edge ends the hold window.
        if (cnt_q <= HW'(1)) state_d = RUN;
        else                 cnt_d   = cnt_q - HW'(1);
      end
      HALTED: begin
        if (Excp) begin
          state_d = RUN;
          pc_d    = EXC_VEC;
          pend_d  = 1'b0;
        end
      end
      RUN: begin
        if (Excp) begin
          pc_d   = EXC_VEC;
          pend_d = 1'b0;
        end else if (Halt && PCWre) begin
          state_d = HALTED;
        end else if (!PCWre) begin
          if (PCSrc != PC_SEQ) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt;
          end
        end else if (PCSrc != PC_SEQ) begin
          pend_d = 1'b0;
          if (tgt_mis) begin
            pc_d   = EXC_VEC;
            aerr_d = 1'b1;
          end else begin
            pc_d = tgt;
          end
        end else if (pend_q) begin
          // Branch/jump targets are aligned, so low bits set means a bad JR.
          pend_d = 1'b0;
          if (|pend_tgt_q[1:0]) begin
            pc_d   = EXC_VEC;
            aerr_d = 1'b1;
          end else begin
            pc_d = pend_tgt_q;
          end
        end else begin
          pc_d = PCPlus4;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= HOLD;
      cnt_q      <= HW'(RESET_HOLD);
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      aerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      aerr_q     <= aerr_d;
    end
  end

  assign CurrentAdd = pc_q;
  assign Valid      = (state_q == RUN);
  assign AddrErr    = aerr_q;
  assign Pending    = pend_q;
  assign DbgState   = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: the driver pushes the expected post-edge
// outputs into a queue, a monitor pops and compares after each edge.
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_wre;
  logic [1:0]  pc_src;
  logic [31:0] branch_off;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic        excp;
  logic        halt;
  logic [31:0] current_add;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        addr_err;
  logic        pending;
  logic [1:0]  dbg_state;

  logic [36:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  pc_unit #(.WIDTH(32), .RESET_HOLD(2)) dut (
    .CLK        (clk),
    .Reset      (reset),
    .PCWre      (pc_wre),
    .PCSrc      (pc_src),
    .BranchOff  (branch_off),
    .JumpTarget (jump_target),
    .RegTarget  (reg_target),
    .Excp       (excp),
    .Halt       (halt),
    .CurrentAdd (current_add),
    .PCPlus4    (pc_plus4),
    .Valid      (valid),
    .AddrErr    (addr_err),
    .Pending    (pending),
    .DbgState   (dbg_state)
  );

  // Clock and reset-free idle generation.
  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0; pc_wre = 1'b1; pc_src = PC_SEQ; branch_off = '0;
    jump_target = '0; reg_target = '0; excp = 1'b0; halt = 1'b0;
  endtask

  // Driver: queue the expected post-edge outputs, then let the edge happen.
  task automatic tick(input logic [31:0] pc, input logic v, input logic ae,
                      input logic pd, input logic [1:0] st, input string tag);
    exp_q.push_back({pc, v, ae, pd, st});
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare outputs 1 time unit after each active edge.
  always @(posedge clk) begin
    logic [36:0] e, got;
    logic [31:0] e_pc4;
    string t;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      e_pc4 = e[36:5] + 32'd4;
      got = {current_add, valid, addr_err, pending, dbg_state};
      total++;
      if (got !== e || pc_plus4 !== e_pc4) begin
        bad++;
        $display("FAIL %s: got pc=%h pc4=%h v=%b ae=%b pd=%b st=%0d, want pc=%h pc4=%h v=%b ae=%b pd=%b st=%0d",
                 t, current_add, pc_plus4, valid, addr_err, pending, dbg_state,
                 e[36:5], e_pc4, e[4], e[3], e[2], e[1:0]);
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    tick(32'h0, 0, 0, 0, HOLD, "reset");
    reset = 1'b0;
    tick(32'h0, 0, 0, 0, HOLD, "hold1");
    tick(32'h0, 1, 0, 0, RUN, "run0");
    for (int a = 4; a <= 'h10; a += 4) tick(32'(a), 1, 0, 0, RUN, "seq_a");

    // Backward branch from 0x10.
    pc_src = PC_BR; branch_off = -32'sd2;
    tick(32'h0C, 1, 0, 0, RUN, "branch_back");
    idle();
    for (int a = 'h10; a <= 'h20; a += 4) tick(32'(a), 1, 0, 0, RUN, "seq_b");

    // Stalled jump is buffered, then released by a sequential enable.
    pc_wre = 1'b0; pc_src = PC_J; jump_target = 26'h40;
    tick(32'h20, 1, 0, 1, RUN, "stall_j");
    pc_src = PC_SEQ;
    repeat (3) tick(32'h20, 1, 0, 1, RUN, "stall_hold");
    pc_wre = 1'b1;
    tick(32'h100, 1, 0, 0, RUN, "pend_load");
    tick(32'h104, 1, 0, 0, RUN, "seq_c");

    // Misaligned live JR.
    pc_src = PC_JR; reg_target = 32'h202;
    tick(32'h80, 1, 1, 0, RUN, "jr_mis");
    idle();
    tick(32'h84, 1, 0, 0, RUN, "ae_clear");

    // Newer stalled redirect overwrites older one.
    pc_wre = 1'b0; pc_src = PC_J; jump_target = 26'h10;
    tick(32'h84, 1, 0, 1, RUN, "stall_j2");
    pc_src = PC_BR; branch_off = 32'd4;
    tick(32'h84, 1, 0, 1, RUN, "stall_br_ovw");
    idle();
    tick(32'h98, 1, 0, 0, RUN, "ovw_load");

    // Live redirect beats the buffered one.
    pc_wre = 1'b0; pc_src = PC_J; jump_target = 26'h10;
    tick(32'h98, 1, 0, 1, RUN, "stall_j3");
    pc_wre = 1'b1; pc_src = PC_JR; reg_target = 32'h300;
    tick(32'h300, 1, 0, 0, RUN, "live_beats");
    idle();
    tick(32'h304, 1, 0, 0, RUN, "no_stale");

    // Buffered misaligned JR.
    pc_wre = 1'b0; pc_src = PC_JR; reg_target = 32'h501;
    tick(32'h304, 1, 0, 1, RUN, "stall_jr_mis");
    idle();
    tick(32'h80, 1, 1, 0, RUN, "pend_mis");
    tick(32'h84, 1, 0, 0, RUN, "ae_clear2");

    // Exception during stall clears pending.
    pc_wre = 1'b0; pc_src = PC_J; jump_target = 26'h10;
    tick(32'h84, 1, 0, 1, RUN, "stall_j4");
    pc_src = PC_SEQ; excp = 1'b1;
    tick(32'h80, 1, 0, 0, RUN, "excp_stall");
    idle();
    tick(32'h84, 1, 0, 0, RUN, "excp_no_pend");

    // Jump to 0x30 and halt there.
    pc_src = PC_J; jump_target = 26'h0C;
    tick(32'h30, 1, 0, 0, RUN, "jump_30");
    idle(); halt = 1'b1;
    tick(32'h30, 0, 0, 0, HALTED, "halt");
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pc_wre = 1'(i & 1); pc_src = 2'((i % 3) + 1);
      branch_off = 32'd5; jump_target = 26'h123; reg_target = 32'h700;
      tick(32'h30, 0, 0, 0, HALTED, "halted");
    end
    idle(); excp = 1'b1;
    tick(32'h80, 1, 0, 0, RUN, "halt_excp");
    idle();
    tick(32'h84, 1, 0, 0, RUN, "seq_d");

    // Pending redirect discarded by reset; inputs ignored during hold.
    pc_wre = 1'b0; pc_src = PC_JR; reg_target = 32'h400;
    tick(32'h84, 1, 0, 1, RUN, "stall_jr400");
    idle(); reset = 1'b1;
    tick(32'h0, 0, 0, 0, HOLD, "reset2");
    idle(); excp = 1'b1; pc_src = PC_J; jump_target = 26'h3FF;
    tick(32'h0, 0, 0, 0, HOLD, "hold_ign");
    idle();
    tick(32'h0, 1, 0, 0, RUN, "run0_b");
    for (int a = 4; a <= 'h40; a += 4) tick(32'(a), 1, 0, 0, RUN, "seq_e");

    // Wrap-around at the top of the address space.
    pc_src = PC_JR; reg_target = 32'hFFFF_FFFC;
    tick(32'hFFFF_FFFC, 1, 0, 0, RUN, "jr_top");
    idle();
    tick(32'h0, 1, 0, 0, RUN, "wrap");
    tick(32'h4, 1, 0, 0, RUN, "after_wrap");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
